mem_stage_ctrl: RTL

//  MEM-stage consumer of the EX/MEM pipeline register. Resolves branch/jump redirects,

---
 rtl/mem_stage_ctrl_pkg.sv | 7 +
 rtl/mem_wb_reg.sv | 39 +++
 rtl/mem_stage_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types and constants for the MEM-stage controller.
package mem_stage_ctrl_pkg;
  localparam int DW     = 32;
  localparam int RA_REG = 31;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;
endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB output bank: valid tracks the completion strobe every cycle, payload loads only on completion.
module mem_wb_reg #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld,
  input  logic          regwrite,
  input  logic          memtoreg,
  input  logic [DW-1:0] rdata,
  input  logic [DW-1:0] alu,
  input  logic [4:0]    dst,
  output logic          wb_valid,
  output logic          wb_regwrite,
  output logic          wb_memtoreg,
  output logic [DW-1:0] wb_rdata,
  output logic [DW-1:0] wb_alu,
  output logic [4:0]    wb_dst
);
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid    <= 1'b0;
      wb_regwrite <= 1'b0;
      wb_memtoreg <= 1'b0;
      wb_rdata    <= '0;
      wb_alu      <= '0;
      wb_dst      <= '0;
    end else begin
      wb_valid <= ld;
      if (ld) begin
        wb_regwrite <= regwrite;
        wb_memtoreg <= memtoreg;
        wb_rdata    <= rdata;
        wb_alu      <= alu;
        wb_dst      <= dst;
      end
    end
  end
endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage control: redirect resolution, data-memory handshake with timeout, MEM/WB drive.
module mem_stage_ctrl #(
  parameter int DW      = mem_stage_ctrl_pkg::DW,
  parameter int TIMEOUT = 16,
  parameter int RA_REG  = mem_stage_ctrl_pkg::RA_REG
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          Mvalid,
  input  logic          Mbranch,
  input  logic          Mmemread,
  input  logic          Mmemtoreg,
  input  logic          Mmemwrite,
  input  logic          Mregwrite,
  input  logic          Mcntrljalr,
  input  logic          Mcntrljald,
  input  logic [1:0]    Mcntrljr,
  input  logic [25:0]   M250Inst,
  input  logic [DW-1:0] MRD1,
  input  logic [DW-1:0] MRD2,
  input  logic [DW-1:0] MPCAddResult,
  input  logic [DW-1:0] MAddResult,
  input  logic          MAluZero,
  input  logic [DW-1:0] MAluResult,
  input  logic [4:0]    MRegDst,
  output logic          MemReq,
  output logic          MemWe,
  output logic [DW-1:0] MemAddr,
  output logic [DW-1:0] MemWData,
  input  logic          MemAck,
  input  logic [DW-1:0] MemRData,
  output logic          MemStall,
  output logic          PCSrc,
  output logic [DW-1:0] PCTarget,
  output logic          WBvalid,
  output logic          WBregwrite,
  output logic          WBmemtoreg,
  output logic [DW-1:0] WBReadData,
  output logic [DW-1:0] WBAluResult,
  output logic [4:0]    WBRegDst,
  output logic          MemErr
);
  import mem_stage_ctrl_pkg::*;

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          memop, tmo, link, wb_ld;
  logic [DW-1:0] jtgt, wb_alu, wb_rdata;
  logic [4:0]    wb_dst;

  assign memop = Mvalid & (Mmemread | Mmemwrite);
  // cnt holds the number of finished WAIT cycles, so the TIMEOUT-th one aborts
  assign tmo   = (state == WAIT) && (cnt == CW'(TIMEOUT - 1));
  assign MemStall = ((state == IDLE) & memop) | ((state == WAIT) & ~MemAck & ~tmo);

  assign jtgt = DW'({MPCAddResult[DW-1:DW-4], M250Inst, 2'b00});

  always_comb begin
    PCSrc    = 1'b0;
    PCTarget = '0;
    if (Mvalid && state == IDLE) begin
      if (Mcntrljr != 2'b00 || Mcntrljalr) begin
        PCSrc    = 1'b1;
        PCTarget = MRD1;
      end else if (Mcntrljald) begin
        PCSrc    = 1'b1;
        PCTarget = jtgt;
      end else if (Mbranch && MAluZero) begin
        PCSrc    = 1'b1;
        PCTarget = MAddResult;
      end
    end
  end

  // Completion: non-mem instruction in IDLE, or the ack of an outstanding access
  assign wb_ld    = ((state == IDLE) & Mvalid & ~memop) | ((state == WAIT) & MemAck);
  assign link     = Mcntrljald | Mcntrljalr;
  assign wb_alu   = link ? MPCAddResult : MAluResult;
  assign wb_dst   = link ? 5'(RA_REG) : MRegDst;
  assign wb_rdata = ((state == WAIT) && !MemWe) ? MemRData : '0;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= IDLE;
      cnt      <= '0;
      MemReq   <= 1'b0;
      MemWe    <= 1'b0;
      MemAddr  <= '0;
      MemWData <= '0;
      MemErr   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (memop) begin
          state    <= WAIT;
          cnt      <= '0;
          MemReq   <= 1'b1;
          MemWe    <= Mmemwrite;
          MemAddr  <= MAluResult;
          MemWData <= MRD2;
        end
        WAIT: if (MemAck) begin
          state  <= IDLE;
          MemReq <= 1'b0;
        end else if (tmo) begin
          state  <= IDLE;
          MemReq <= 1'b0;
          MemErr <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  mem_wb_reg #(.DW(DW)) u_wb (
    .clk        (Clk),
    .rst        (Rst),
    .ld         (wb_ld),
    .regwrite   (Mregwrite | link),
    .memtoreg   (Mmemtoreg),
    .rdata      (wb_rdata),
    .alu        (wb_alu),
    .dst        (wb_dst),
    .wb_valid   (WBvalid),
    .wb_regwrite(WBregwrite),
    .wb_memtoreg(WBmemtoreg),
    .wb_rdata   (WBReadData),
    .wb_alu     (WBAluResult),
    .wb_dst     (WBRegDst)
  );
endmodule
